// File: rtl/servisia_mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : servisia_mem_ctrl_pkg
// Description : Shared types and constants for the Servisia memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
package servisia_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_WAIT = 2'd2,
        ST_ACK  = 2'd3
    } state_e;

    localparam int   BYTES_PER_WORD = 4;
    localparam logic GNT_IBUS       = 1'b0;
    localparam logic GNT_DBUS       = 1'b1;

endpackage
`default_nettype wire

// File: rtl/servisia_mem_seq.sv
`default_nettype none
// ============================================================================
// Module      : servisia_mem_seq
// Description : Latches one word request and walks it as four byte accesses,
//               assembling read bytes little-endian into the rdt register.
// Revision    : 1.0 - initial release
// ============================================================================
module servisia_mem_seq
    import servisia_mem_ctrl_pkg::*;
#(
    parameter int MEM_AW = 20
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              we_i,
    input  logic [MEM_AW-1:2] adr_i,
    input  logic [31:0]       dat_i,
    input  logic [3:0]        sel_i,
    input  logic [7:0]        mem_rdata_i,
    output logic              idle_o,
    output logic              ack_o,
    output logic [31:0]       rdt_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o
);

    state_e              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic                we_q;
    logic [MEM_AW-1:2]   adr_q;
    logic [31:0]         dat_q;
    logic [3:0]          sel_q;
    logic                rd_pend_q;
    logic [31:0]         rdt_q;
    logic                w_xfer;
    logic [1:0]          w_lane;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_XFER;
                    cnt_d   = 2'd0;
                end
            end
            ST_XFER: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'(BYTES_PER_WORD - 1)) begin
                    state_d = we_q ? ST_ACK : ST_WAIT;
                end
            end
            ST_WAIT: state_d = ST_ACK;
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Read bytes return one cycle late, so the lane trails the counter by one;
    // the last byte lands in WAIT after the counter has wrapped to 0.
    assign w_lane = cnt_q - 2'd1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 2'd0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= 32'h0;
            sel_q     <= 4'h0;
            rd_pend_q <= 1'b0;
            rdt_q     <= 32'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_pend_q <= mem_read_o;
            if (start_i && idle_o) begin
                we_q  <= we_i;
                adr_q <= adr_i;
                dat_q <= dat_i;
                sel_q <= sel_i;
            end
            if (rd_pend_q) begin
                rdt_q[{w_lane, 3'b000} +: 8] <= mem_rdata_i;
            end
        end
    end

    assign w_xfer      = (state_q == ST_XFER);
    assign idle_o      = (state_q == ST_IDLE);
    assign ack_o       = (state_q == ST_ACK);
    assign rdt_o       = rdt_q;
    assign mem_read_o  = w_xfer & ~we_q;
    assign mem_write_o = w_xfer & we_q & sel_q[cnt_q];
    assign mem_addr_o  = w_xfer ? {adr_q, cnt_q} : '0;
    assign mem_wdata_o = (w_xfer & we_q) ? dat_q[{cnt_q, 3'b000} +: 8] : 8'h00;

endmodule
`default_nettype wire

// File: rtl/servisia_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : servisia_mem_ctrl
// Description : Two-port (fetch/data) arbiter in front of the byte sequencer;
//               data has fixed priority, acks routed by the grant register.
// Revision    : 1.0 - initial release
// ============================================================================
module servisia_mem_ctrl
    import servisia_mem_ctrl_pkg::*;
#(
    parameter int MEM_AW = 20
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ibus_cyc_i,
    input  logic [31:0]       ibus_adr_i,
    output logic [31:0]       ibus_rdt_o,
    output logic              ibus_ack_o,
    input  logic              dbus_cyc_i,
    input  logic              dbus_we_i,
    input  logic [31:0]       dbus_adr_i,
    input  logic [31:0]       dbus_dat_i,
    input  logic [3:0]        dbus_sel_i,
    output logic [31:0]       dbus_rdt_o,
    output logic              dbus_ack_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    input  logic [7:0]        mem_rdata_i
);

    logic              grant_q;
    logic              w_idle;
    logic              w_start;
    logic              w_seq_ack;
    logic              w_we;
    logic [MEM_AW-1:2] w_adr;
    logic [31:0]       w_dat;
    logic [3:0]        w_sel;
    logic [31:0]       w_rdt;
    logic              unused_adr_bits;

    assign w_start = w_idle & (dbus_cyc_i | ibus_cyc_i);
    assign w_we    = dbus_cyc_i & dbus_we_i;
    assign w_adr   = dbus_cyc_i ? dbus_adr_i[MEM_AW-1:2] : ibus_adr_i[MEM_AW-1:2];
    assign w_dat   = dbus_cyc_i ? dbus_dat_i : 32'h0;
    assign w_sel   = dbus_cyc_i ? dbus_sel_i : 4'h0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            grant_q <= GNT_IBUS;
        end else if (w_start) begin
            grant_q <= dbus_cyc_i ? GNT_DBUS : GNT_IBUS;
        end
    end

    servisia_mem_seq #(
        .MEM_AW (MEM_AW)
    ) u_seq (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (w_start),
        .we_i        (w_we),
        .adr_i       (w_adr),
        .dat_i       (w_dat),
        .sel_i       (w_sel),
        .mem_rdata_i (mem_rdata_i),
        .idle_o      (w_idle),
        .ack_o       (w_seq_ack),
        .rdt_o       (w_rdt),
        .mem_read_o  (mem_read_o),
        .mem_write_o (mem_write_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o)
    );

    assign ibus_ack_o = w_seq_ack & (grant_q == GNT_IBUS);
    assign dbus_ack_o = w_seq_ack & (grant_q == GNT_DBUS);
    assign ibus_rdt_o = w_rdt;
    assign dbus_rdt_o = w_rdt;

    // Word-offset and out-of-window address bits carry no meaning here.
    assign unused_adr_bits = ^{ibus_adr_i[31:MEM_AW], ibus_adr_i[1:0],
                               dbus_adr_i[31:MEM_AW], dbus_adr_i[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_servisia_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_servisia_mem_ctrl
// Description : Self-checking bench: transaction-level reference model plus
//               directed scenarios and two randomized bus masters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_servisia_mem_ctrl;

    localparam int MEM_AW = 20;
    localparam int MSIZE  = 1 << MEM_AW;
    localparam int WIN    = 1024;

    logic              clk_i      = 1'b0;
    logic              rst_i      = 1'b1;
    logic              ibus_cyc_i = 1'b0;
    logic [31:0]       ibus_adr_i = 32'h0;
    logic [31:0]       ibus_rdt_o;
    logic              ibus_ack_o;
    logic              dbus_cyc_i = 1'b0;
    logic              dbus_we_i  = 1'b0;
    logic [31:0]       dbus_adr_i = 32'h0;
    logic [31:0]       dbus_dat_i = 32'h0;
    logic [3:0]        dbus_sel_i = 4'h0;
    logic [31:0]       dbus_rdt_o;
    logic              dbus_ack_o;
    logic              mem_read_o;
    logic              mem_write_o;
    logic [MEM_AW-1:0] mem_addr_o;
    logic [7:0]        mem_wdata_o;
    logic [7:0]        mem_rdata_i;

    servisia_mem_ctrl #(.MEM_AW(MEM_AW)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .ibus_cyc_i  (ibus_cyc_i),
        .ibus_adr_i  (ibus_adr_i),
        .ibus_rdt_o  (ibus_rdt_o),
        .ibus_ack_o  (ibus_ack_o),
        .dbus_cyc_i  (dbus_cyc_i),
        .dbus_we_i   (dbus_we_i),
        .dbus_adr_i  (dbus_adr_i),
        .dbus_dat_i  (dbus_dat_i),
        .dbus_sel_i  (dbus_sel_i),
        .dbus_rdt_o  (dbus_rdt_o),
        .dbus_ack_o  (dbus_ack_o),
        .mem_read_o  (mem_read_o),
        .mem_write_o (mem_write_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;
    int cyc_n  = 0;
    always @(posedge clk_i) cyc_n <= cyc_n + 1;

    logic [7:0]  phys [MSIZE];
    logic [7:0]  refm [MSIZE];
    logic        init_en = 1'b0;
    logic        pl_en   = 1'b0;
    logic [19:0] pl_addr = 20'h0;
    logic [7:0]  pl_data = 8'h0;

    function automatic logic [7:0] seed_byte(input int a);
        return 8'((a * 29) ^ (a >> 3) ^ 32'h5A);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=0x%08h required=0x%08h", name, cyc_n, act, exp);
        end
    endtask

    // Registered byte memory the controller talks to.
    always @(posedge clk_i) begin
        if (init_en) begin
            for (int h = 0; h < 2; h++)
                for (int i = 0; i < WIN; i++)
                    phys[(h << 19) | i] <= seed_byte((h << 19) | i);
        end
        if (pl_en)       phys[pl_addr]    <= pl_data;
        if (mem_write_o) phys[mem_addr_o] <= mem_wdata_o;
        if (mem_read_o)  mem_rdata_i      <= phys[mem_addr_o];
    end

    // Reference model: one transaction at a time, timed from its acceptance.
    bit          busy = 1'b0;
    bit          t_port, t_we;
    logic [19:0] t_base;
    logic [31:0] t_dat, t_word, t_adr;
    logic [3:0]  t_sel;
    int          t_start;
    logic [31:0] last_rdt = 32'h0;

    always @(negedge clk_i) begin : model_cmp
        int k;
        bit e_rd, e_wr, e_iack, e_dack;
        logic [19:0] e_addr;
        logic [7:0]  e_wd;
        if (init_en) begin
            for (int h = 0; h < 2; h++)
                for (int i = 0; i < WIN; i++)
                    refm[(h << 19) | i] = seed_byte((h << 19) | i);
        end
        if (pl_en) refm[pl_addr] = pl_data;
        if (rst_i) begin
            chk("rst_ctrl", {ibus_ack_o, dbus_ack_o, mem_read_o, mem_write_o, mem_wdata_o, mem_addr_o}, 32'h0);
            chk("rst_ibus_rdt", ibus_rdt_o, 32'h0);
            chk("rst_dbus_rdt", dbus_rdt_o, 32'h0);
            busy     = 1'b0;
            last_rdt = 32'h0;
        end else begin
            k = 0; e_rd = 0; e_wr = 0; e_iack = 0; e_dack = 0; e_addr = 20'h0; e_wd = 8'h0;
            if (busy) begin
                k = cyc_n - t_start;
                if (k >= 0 && k < 4) begin
                    e_rd   = !t_we;
                    e_wr   = t_we && t_sel[k];
                    e_addr = t_base + 20'(k);
                    e_wd   = 8'(t_dat >> (8 * k));
                end
                if (k == (t_we ? 4 : 5)) begin
                    if (t_port) e_dack = 1'b1;
                    else        e_iack = 1'b1;
                end
            end
            chk("mem_read", {31'h0, mem_read_o}, {31'h0, e_rd});
            chk("mem_write", {31'h0, mem_write_o}, {31'h0, e_wr});
            chk("ibus_ack", {31'h0, ibus_ack_o}, {31'h0, e_iack});
            chk("dbus_ack", {31'h0, dbus_ack_o}, {31'h0, e_dack});
            if (busy && k >= 0 && k < 4) chk("mem_addr", {12'h0, mem_addr_o}, {12'h0, e_addr});
            if (e_wr) chk("mem_wdata", {24'h0, mem_wdata_o}, {24'h0, e_wd});
            if (e_iack || e_dack) begin
                if (!t_we) last_rdt = t_word;
                chk("ack_ibus_rdt", ibus_rdt_o, last_rdt);
                chk("ack_dbus_rdt", dbus_rdt_o, last_rdt);
            end else if (!(busy && !t_we)) begin
                chk("hold_ibus_rdt", ibus_rdt_o, last_rdt);
                chk("hold_dbus_rdt", dbus_rdt_o, last_rdt);
            end
            if (e_wr) refm[e_addr] = e_wd;
            if (e_iack || e_dack) begin
                busy = 1'b0;
            end else if (!busy && (dbus_cyc_i || ibus_cyc_i)) begin
                t_port  = dbus_cyc_i;
                t_we    = dbus_cyc_i && dbus_we_i;
                t_adr   = dbus_cyc_i ? dbus_adr_i : ibus_adr_i;
                t_base  = 20'(t_adr & 32'h000F_FFFC);
                t_dat   = dbus_cyc_i ? dbus_dat_i : 32'h0;
                t_sel   = dbus_cyc_i ? dbus_sel_i : 4'h0;
                t_word  = {refm[t_base + 20'd3], refm[t_base + 20'd2],
                           refm[t_base + 20'd1], refm[t_base]};
                t_start = cyc_n + 1;
                busy    = 1'b1;
            end
        end
    end

    task automatic at_cycle(input int target);
        @(negedge clk_i);
        while (cyc_n < target) @(negedge clk_i);
    endtask

    task automatic wait_ack(input bit port, input int max, output int at);
        int t;
        t  = 0;
        at = -1;
        while (t < max && at < 0) begin
            @(negedge clk_i);
            if (port ? dbus_ack_o : ibus_ack_o) at = cyc_n;
            t++;
        end
        if (at < 0) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout port=%0d actual=none required=ack within %0d cycles", port, max);
        end
    endtask

    task automatic preload(input logic [19:0] addr, input logic [31:0] word);
        for (int j = 0; j < 4; j++) begin
            @(posedge clk_i); #1;
            pl_en   = 1'b1;
            pl_addr = addr + 20'(j);
            pl_data = 8'(word >> (8 * j));
        end
        @(posedge clk_i); #1;
        pl_en = 1'b0;
    endtask

    function automatic logic [31:0] rnd_adr();
        logic [31:0] r;
        r = $urandom();
        r = (r & 32'hFFF0_0003) | (32'($urandom_range(0, 1)) << 19)
          | (32'($urandom_range(0, 63)) << 2);
        return r;
    endfunction

    task automatic ibus_master(input int n);
        int at;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(1, 4)) @(posedge clk_i);
            #1;
            ibus_adr_i = rnd_adr();
            ibus_cyc_i = 1'b1;
            wait_ack(1'b0, 60, at);
            ibus_cyc_i = 1'b0;
        end
    endtask

    task automatic dbus_master(input int n);
        int at;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(1, 4)) @(posedge clk_i);
            #1;
            dbus_adr_i = rnd_adr();
            dbus_we_i  = 1'($urandom_range(0, 1));
            dbus_dat_i = $urandom();
            dbus_sel_i = 4'($urandom_range(0, 15));
            dbus_cyc_i = 1'b1;
            wait_ack(1'b1, 60, at);
            dbus_cyc_i = 1'b0;
        end
    endtask

    initial begin : stim
        int n, at, dack_at, iack_at, acks, diffs;

        // Reset with random inputs, memory seeded meanwhile.
        @(posedge clk_i); #1;
        init_en = 1'b1;
        @(posedge clk_i); #1;
        init_en = 1'b0;
        preload(20'h00104, 32'h44332211);
        preload(20'h80020, 32'hA3A2A1A0);
        repeat (4) begin
            @(posedge clk_i); #1;
            ibus_cyc_i = 1'($urandom_range(0, 1)); ibus_adr_i = $urandom();
            dbus_cyc_i = 1'($urandom_range(0, 1)); dbus_we_i  = 1'($urandom_range(0, 1));
            dbus_adr_i = $urandom(); dbus_dat_i = $urandom(); dbus_sel_i = 4'($urandom_range(0, 15));
        end
        @(negedge clk_i);
        chk("rst_rand_addr", {12'h0, mem_addr_o}, 32'h0);
        chk("rst_rand_strobes", {30'h0, mem_read_o, mem_write_o}, 32'h0);
        ibus_cyc_i = 1'b0; dbus_cyc_i = 1'b0; dbus_we_i = 1'b0;
        @(posedge clk_i); #2;
        rst_i = 1'b0;

        // Fetch of a known word; upper address bits must be ignored.
        @(posedge clk_i); #1;
        ibus_adr_i = 32'hFFF0_0104;
        ibus_cyc_i = 1'b1;
        n = cyc_n;
        for (int c = 1; c <= 4; c++) begin
            at_cycle(n + c);
            chk("fetch_addr", {12'h0, mem_addr_o}, 32'h104 + 32'(c - 1));
            chk("fetch_read", {31'h0, mem_read_o}, 32'h1);
        end
        wait_ack(1'b0, 20, at);
        chk("fetch_ack_cycle", 32'(at - n), 32'd6);
        chk("fetch_rdt", ibus_rdt_o, 32'h44332211);
        ibus_cyc_i = 1'b0;

        // Partial-select write: strobes only on lanes 0 and 2.
        @(posedge clk_i); #1;
        dbus_adr_i = 32'h0008_0010; dbus_dat_i = 32'hDEADBEEF; dbus_sel_i = 4'b0101;
        dbus_we_i = 1'b1; dbus_cyc_i = 1'b1;
        n = cyc_n;
        at_cycle(n + 1);
        chk("wr_c1", {mem_read_o, mem_write_o, 2'b00, mem_addr_o, mem_wdata_o}, {2'b01, 2'b00, 20'h80010, 8'hEF});
        at_cycle(n + 2);
        chk("wr_c2_strobe", {30'h0, mem_read_o, mem_write_o}, 32'h0);
        at_cycle(n + 3);
        chk("wr_c3", {mem_read_o, mem_write_o, 2'b00, mem_addr_o, mem_wdata_o}, {2'b01, 2'b00, 20'h80012, 8'hAD});
        at_cycle(n + 4);
        chk("wr_c4_strobe", {30'h0, mem_read_o, mem_write_o}, 32'h0);
        at_cycle(n + 5);
        chk("wr_c5_ack", {30'h0, ibus_ack_o, dbus_ack_o}, 32'h1);
        dbus_cyc_i = 1'b0; dbus_we_i = 1'b0;

        // Simultaneous requests: data first, fetch one idle cycle later.
        @(posedge clk_i); #1;
        dbus_adr_i = 32'h0008_0040; dbus_we_i = 1'b0; dbus_cyc_i = 1'b1;
        ibus_adr_i = 32'h0000_0200; ibus_cyc_i = 1'b1;
        n = cyc_n; dack_at = -1; iack_at = -1;
        for (int c = 1; c <= 15; c++) begin
            at_cycle(n + c);
            chk("ack_overlap", {31'h0, ibus_ack_o & dbus_ack_o}, 32'h0);
            if (dbus_ack_o) begin dack_at = c; dbus_cyc_i = 1'b0; end
            if (ibus_ack_o) begin iack_at = c; ibus_cyc_i = 1'b0; end
        end
        chk("arb_dack_cycle", 32'(dack_at), 32'd6);
        chk("arb_iack_cycle", 32'(iack_at), 32'd13);
        dbus_cyc_i = 1'b0; ibus_cyc_i = 1'b0;

        // Data master abandons cyc mid-read; the access still completes.
        @(posedge clk_i); #1;
        dbus_adr_i = 32'h0008_0100; dbus_we_i = 1'b0; dbus_cyc_i = 1'b1;
        n = cyc_n;
        at_cycle(n + 2);
        dbus_cyc_i = 1'b0;
        wait_ack(1'b1, 20, at);
        chk("drop_ack_cycle", 32'(at - n), 32'd6);

        // Reset lands in C3 of a full write: only C1/C2 bytes reach memory.
        @(posedge clk_i); #1;
        dbus_adr_i = 32'h0008_0020; dbus_dat_i = 32'hCAFEF00D; dbus_sel_i = 4'hF;
        dbus_we_i = 1'b1; dbus_cyc_i = 1'b1;
        n = cyc_n;
        while (cyc_n < n + 3) begin @(posedge clk_i); #2; end
        rst_i = 1'b1;
        #1;
        chk("rst_c3_write", {31'h0, mem_write_o}, 32'h0);
        chk("rst_c3_ctrl", {ibus_ack_o, dbus_ack_o, mem_read_o, mem_write_o, mem_wdata_o, mem_addr_o}, 32'h0);
        dbus_cyc_i = 1'b0; dbus_we_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #2 rst_i = 1'b0;
        acks = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i);
            if (ibus_ack_o || dbus_ack_o) acks++;
        end
        chk("no_ack_after_rst", 32'(acks), 32'h0);
        @(posedge clk_i); #1;
        ibus_adr_i = 32'hABC8_0020; ibus_cyc_i = 1'b1;
        n = cyc_n;
        wait_ack(1'b0, 20, at);
        chk("post_rst_ack_cycle", 32'(at - n), 32'd6);
        chk("post_rst_rdt", ibus_rdt_o, 32'hA3A2F00D);
        ibus_cyc_i = 1'b0;

        // Two randomized masters contending.
        @(posedge clk_i); #1;
        fork
            ibus_master(60);
            dbus_master(60);
        join
        repeat (10) @(posedge clk_i);

        diffs = 0;
        for (int h = 0; h < 2; h++)
            for (int i = 0; i < WIN; i++)
                if (phys[(h << 19) | i] !== refm[(h << 19) | i]) diffs++;
        chk("mem_image", 32'(diffs), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/servisia_mem_ctrl.md
# servisia_mem_ctrl

Word-to-byte memory controller and two-port arbiter for the Servisia byte-wide memory block (flash at addr[19]=0, SRAM at addr[19]=1). Accepts 32-bit instruction-fetch and data requests from the SERV core. Sequences each request as four consecutive byte accesses on the 8-bit memory port, then assembles and returns read data with a single-cycle acknowledge. Sits between the core bus and the memory block; it is the memory block's only master.

## Interface
Parameters:
- MEM_AW, 20, memory byte-address width; request address bits above MEM_AW-1 are ignored.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- ibus_cyc_i  in  1  instruction-fetch request, held until ibus_ack_o.
- ibus_adr_i  in  32  fetch word address; bits [1:0] ignored.
- ibus_rdt_o  out  32  fetch read data; valid while ibus_ack_o.
- ibus_ack_o  out  1  one-cycle fetch acknowledge.
- dbus_cyc_i  in  1  data request, held until dbus_ack_o.
- dbus_we_i  in  1  1 = write, 0 = read.
- dbus_adr_i  in  32  data word address; bits [1:0] ignored.
- dbus_dat_i  in  32  write data.
- dbus_sel_i  in  4  write byte enables; ignored for reads.
- dbus_rdt_o  out  32  data read data; valid while dbus_ack_o.
- dbus_ack_o  out  1  one-cycle data acknowledge.
- mem_read_o  out  1  byte read strobe to the memory block.
- mem_write_o  out  1  byte write strobe to the memory block.
- mem_addr_o  out  MEM_AW  byte address.
- mem_wdata_o  out  8  write byte.
- mem_rdata_i  in  8  registered read byte; valid one cycle after mem_read_o.

## Operation
- States: IDLE, XFER, WAIT, ACK. A 2-bit byte counter cnt is active in XFER.
- Acceptance:
  - In IDLE, dbus_cyc_i has fixed priority over ibus_cyc_i.
  - The winner is latched in a grant register, together with address, we, dat and sel (treated as 0 for ibus).
  - Transition to XFER with cnt=0.
- XFER:
  - mem_addr_o = {adr[MEM_AW-1:2], cnt}.
  - Read: mem_read_o=1.
  - Write: mem_write_o = sel[cnt], mem_wdata_o = dat[8*cnt+7 : 8*cnt].
  - cnt increments each cycle. After cnt=3, go to WAIT for a read or ACK for a write.
  - The address walks all four bytes even when some sel bits are 0.
- WAIT: no strobes; captures the last read byte.
- Read assembly: in the cycle after each mem_read_o, mem_rdata_i is stored into byte lane cnt-1 of the rdt register (little-endian; byte k goes to rdt[8k+7:8k]).
- ACK:
  - Pulse the granted port's ack for one cycle; the other ack stays 0.
  - Both rdt outputs drive the shared rdt register, which holds its value until the next read capture.
  - Return to IDLE. cyc is not sampled in ACK.
- A master that drops cyc mid-transaction does not abort it; the sequence completes and ack still pulses.
- Reset: state IDLE, cnt 0, grant 0, rdt 0. All outputs are 0 immediately and asynchronously, including a reset asserted mid-XFER. A write byte in flight is cut short; no ack is issued.
- mem_read_o and mem_write_o are never high together. ibus_ack_o and dbus_ack_o are never high together.

## Timing
- Acceptance edge E0. XFER occupies cycles C1–C4.
- Read: WAIT in C5, ack in C6 (6 cycles).
- Write: ack in C5 (5 cycles).
- Next acceptance is possible at the edge ending the first IDLE cycle after ack, so back-to-back throughput is one read per 7 cycles and one write per 6 cycles.
- All outputs are registered or decoded from state registers only. There is no combinational path from any *_i input to any output.

## Structure
- Package servisia_mem_ctrl_pkg holds:
  - the state enum (IDLE, XFER, WAIT, ACK);
  - BYTES_PER_WORD = 4;
  - grant encodings (GNT_IBUS, GNT_DBUS).
- One sub-module, servisia_mem_seq, is natural: it holds the latched request, byte counter, strobe generation and rdt assembly.
- servisia_mem_ctrl keeps the arbitration, grant register and ack routing.

## Test plan
- Reset: assert rst_i with random inputs -> every output is 0, including mid-cycle assertion.
- ibus fetch, adr 0xFFF0_0104, memory bytes 0x11/0x22/0x33/0x44 at 0x104–0x107:
  - mem_addr_o = 0x00104..0x00107 in C1–C4 with mem_read_o=1;
  - ibus_ack_o in C6 only, ibus_rdt_o = 0x44332211.
- dbus write, adr 0x0008_0010, dat 0xDEADBEEF, sel 4'b0101:
  - mem_write_o=1 in C1 (addr 0x80010, wdata 0xEF) and C3 (addr 0x80012, wdata 0xAD);
  - mem_write_o=0 in C2 and C4;
  - dbus_ack_o in C5; mem_read_o stays 0.
- Simultaneous ibus read and dbus read:
  - dbus is served first, with dbus_ack_o at C6;
  - ibus is accepted at the end of C7, with ibus_ack_o at C13;
  - the two acks never overlap.
- rst_i asserted during C3 of a write:
  - strobes drop in the same cycle and no ack is issued;
  - after release, a new ibus read completes with correct data.
- dbus drops cyc in C2 of a read -> the sequence completes and dbus_ack_o still pulses in C6.
